// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU load/store bus: default widths, the wait-counter
// width and the responder state encoding.
package cpu_bus_pkg;

    localparam int CPU_ADDR_W = 8;
    localparam int CPU_DATA_W = 16;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    // True when a word address falls inside an array of `depth` words.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// Request/response handshake bundle between the CPU (master) and its data memory (slave).
interface cpu_mem_responder_if #(
    parameter int ADDR_W = cpu_bus_pkg::CPU_ADDR_W,
    parameter int DATA_W = cpu_bus_pkg::CPU_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/cpu_mem_array.sv
// Single-port DEPTH x DATA_W word array with registered read data; contents are not reset.
module cpu_mem_array
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W,
    parameter int DEPTH  = 200
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              in_range;

    assign in_range = addr_in_range(32'(addr), DEPTH);

    // Out-of-range addresses neither write nor read the storage.
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem_q[addr] <= wdata;
        end
        rdata <= in_range ? mem_q[addr] : '0;
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder: accepts one load/store at a time, waits WAIT_CYCLES, then
// answers over the response handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request (req_ready high outside reset)
// ST_WAIT | request latched, counting down wait states
// ST_RESP | response held on rsp_* until rsp_ready
module cpu_mem_responder
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W      = CPU_ADDR_W,
    parameter int DATA_W      = CPU_DATA_W,
    parameter int DEPTH       = 200,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    cpu_mem_responder_if.slave  bus
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

    mem_state_e            state_q;
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic                  we_q;
    logic                  err_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic                  rsp_load_q;

    logic                  err_d;
    logic                  fire_resp;
    logic                  arr_we;
    logic [DATA_W-1:0]     arr_rdata;

    assign err_d     = !addr_in_range(32'(bus.req_addr), DEPTH);
    // The array acts on the same edge that enters RESP, so its registered read
    // data is valid for the whole response phase.
    assign fire_resp = rst_n && (state_q == ST_WAIT) && (cnt_q == '0);
    assign arr_we    = fire_resp && we_q && !err_q;

    cpu_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (arr_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        err_q   <= err_d;
                        cnt_q   <= WAIT_LOAD;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                        rsp_load_q  <= !we_q && !err_q;
                    end else begin
                        cnt_q <= cnt_q - WAIT_CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_load_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = rst_n && (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_load_q ? arr_rdata : '0;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: one instance with two wait states, one with none.
module tb_cpu_mem_responder;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   acc_a;
    int   hs_a;

    cpu_mem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus_a ();
    cpu_mem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus_b ();

    cpu_mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(200), .WAIT_CYCLES(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    cpu_mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(200), .WAIT_CYCLES(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_a.req_valid && bus_a.req_ready) acc_a <= acc_a + 1;
        if (bus_a.rsp_valid && bus_a.rsp_ready) hs_a <= hs_a + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy_of(input bit s);
        return s ? bus_b.req_ready : bus_a.req_ready;
    endfunction

    function automatic logic vld_of(input bit s);
        return s ? bus_b.rsp_valid : bus_a.rsp_valid;
    endfunction

    task automatic set_req(input bit s, input logic v, input logic we,
                           input logic [7:0] addr, input logic [15:0] wdata);
        if (s) begin
            bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = addr; bus_b.req_wdata = wdata;
        end else begin
            bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = addr; bus_a.req_wdata = wdata;
        end
    endtask

    // One transaction with rsp_ready high; returns response data and the cycle
    // offsets (from the accept edge) of rsp_valid and of req_ready returning.
    task automatic txn(input bit s, input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                       output logic [15:0] rdata, output logic err, output int lat, output int rdy_lat);
        int  t0;
        bit  ok;
        rdata = '0; err = 1'b0; lat = -1; rdy_lat = -1;
        @(negedge clk);
        set_req(s, 1'b1, we, addr, wdata);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (rdy_of(s)) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        t0 = cyc + 1;
        @(posedge clk);
        #1;
        set_req(s, 1'b0, 1'b0, 8'h00, 16'h0000);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (vld_of(s)) begin ok = 1; break; end
        end
        chk("rsp_timeout", 32'(ok), 32'd1);
        lat   = cyc - t0;
        rdata = s ? bus_b.rsp_rdata : bus_a.rsp_rdata;
        err   = s ? bus_b.rsp_err : bus_a.rsp_err;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy_of(s)) begin ok = 1; break; end
        end
        chk("ready_timeout", 32'(ok), 32'd1);
        rdy_lat = cyc - t0;
    endtask

    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat;
        int          rl;
        int          acc0;
        int          hs0;
        bit          ok;

        n_chk = 0; n_fail = 0; cyc = 0; acc_a = 0; hs_a = 0;
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        bus_a.rsp_ready = 1'b1;
        bus_b.rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus_a.rsp_rdata), 32'd0);
        chk("rst_rsp_err",   32'(bus_a.rsp_err),   32'd0);
        chk("rst_b_ready",   32'(bus_b.req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready", 32'(bus_a.req_ready), 32'd1);

        // Store then load, two wait states
        acc0 = acc_a;
        txn(1'b0, 1'b1, 8'h10, 16'hBEEF, rd, er, lat, rl);
        chk("st_lat",   32'(lat), 32'd3);
        chk("st_rdata", 32'(rd),  32'd0);
        chk("st_err",   32'(er),  32'd0);
        chk("st_rdy",   32'(rl),  32'd4);
        chk("st_acc",   32'(acc_a - acc0), 32'd1);
        txn(1'b0, 1'b0, 8'h10, 16'h0000, rd, er, lat, rl);
        chk("ld_lat",   32'(lat), 32'd3);
        chk("ld_rdata", 32'(rd),  32'hBEEF);
        chk("ld_err",   32'(er),  32'd0);

        // Zero wait states
        txn(1'b1, 1'b1, 8'h05, 16'h1234, rd, er, lat, rl);
        chk("w0_st_lat", 32'(lat), 32'd1);
        chk("w0_st_err", 32'(er),  32'd0);
        txn(1'b1, 1'b0, 8'h05, 16'h0000, rd, er, lat, rl);
        chk("w0_ld_lat",   32'(lat), 32'd1);
        chk("w0_ld_rdata", 32'(rd),  32'h1234);
        chk("w0_ld_rdy",   32'(rl),  32'd2);

        // Response back-pressure
        bus_a.rsp_ready = 1'b0;
        hs0 = hs_a;
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus_a.req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("bp_accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_a.rsp_valid) begin ok = 1; break; end
        end
        chk("bp_rsp_timeout", 32'(ok), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus_a.rsp_valid), 32'd1);
            chk("bp_rdata", 32'(bus_a.rsp_rdata), 32'hBEEF);
            chk("bp_err",   32'(bus_a.rsp_err),   32'd0);
            chk("bp_ready", 32'(bus_a.req_ready), 32'd0);
            @(negedge clk);
        end
        bus_a.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop", 32'(bus_a.rsp_valid), 32'd0);
        chk("bp_rdata_clr",  32'(bus_a.rsp_rdata), 32'd0);
        chk("bp_ready_back", 32'(bus_a.req_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("bp_one_rsp", 32'(hs_a - hs0), 32'd1);

        // Out-of-range accesses
        txn(1'b0, 1'b1, 8'd199, 16'h5A5A, rd, er, lat, rl);
        chk("edge_st_err", 32'(er), 32'd0);
        txn(1'b0, 1'b1, 8'hC8, 16'hAAAA, rd, er, lat, rl);
        chk("oor_st_err",   32'(er),  32'd1);
        chk("oor_st_rdata", 32'(rd),  32'd0);
        chk("oor_st_lat",   32'(lat), 32'd3);
        txn(1'b0, 1'b0, 8'hC8, 16'h0000, rd, er, lat, rl);
        chk("oor_ld_err",   32'(er), 32'd1);
        chk("oor_ld_rdata", 32'(rd), 32'd0);
        txn(1'b0, 1'b0, 8'd199, 16'h0000, rd, er, lat, rl);
        chk("edge_ld_rdata", 32'(rd), 32'h5A5A);
        chk("edge_ld_err",   32'(er), 32'd0);
        txn(1'b0, 1'b0, 8'hFF, 16'h0000, rd, er, lat, rl);
        chk("oor_ff_err", 32'(er), 32'd1);

        // req_valid held high: one accept per 5-cycle transaction
        @(negedge clk);
        acc0 = acc_a;
        hs0  = hs_a;
        set_req(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
        repeat (15) @(posedge clk);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        chk("held_accepts", 32'(acc_a - acc0), 32'd3);
        chk("held_rsps",    32'(hs_a - hs0),   32'd3);
        repeat (8) @(negedge clk);

        // Reset during the wait phase of a store
        txn(1'b0, 1'b1, 8'h20, 16'h0001, rd, er, lat, rl);
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b1, 8'h20, 16'h7777);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus_a.req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("rw_accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        rst_n = 1'b0;
        hs0 = hs_a;
        @(negedge clk);
        chk("rw_valid", 32'(bus_a.rsp_valid), 32'd0);
        chk("rw_ready", 32'(bus_a.req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rw_rel_ready", 32'(bus_a.req_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("rw_no_rsp", 32'(hs_a - hs0), 32'd0);
        txn(1'b0, 1'b0, 8'h20, 16'h0000, rd, er, lat, rl);
        chk("rw_ld_rdata", 32'(rd), 32'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
